// File: rtl/uart_packet_tx.sv
// uart_packet_tx
// Frames a packet as header 0x51, a big-endian 16-bit length and the payload
// bytes, then sends each byte as a UART frame: start bit, eight data bits
// LSB first, optional even parity, and one or two stop bits.
// The packet sequencer and the byte serializer share one clocked process so
// that the next framing byte can start the cycle after the last stop bit.
module uart_packet_tx #(
  parameter int CLOCKS_PER_BIT = 868,
  parameter int INCLUDE_PARITY = 1,
  parameter int STOP_BITS      = 1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        packet_valid,
  input  logic [15:0] packet_length,
  output logic        packet_ready,
  input  logic        data_valid,
  input  logic [7:0]  data,
  output logic        data_ready,
  output logic        uart_tx,
  output logic        busy
);

  localparam int             CW          = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0]  BIT_LAST    = CW'(CLOCKS_PER_BIT - 1);
  localparam logic           STOP_LAST   = 1'(STOP_BITS - 1);
  localparam logic [7:0]     HEADER_BYTE = 8'h51;

  typedef enum logic [2:0] {
    PKT_IDLE,
    PKT_HEADER,
    PKT_LEN_HI,
    PKT_LEN_LO,
    PKT_PAYLOAD
  } pkt_state_e;

  typedef enum logic [2:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_PARITY,
    SER_STOP
  } ser_state_e;

  pkt_state_e     pkt_q;
  ser_state_e     ser_q;
  logic [CW-1:0]  bit_cnt_q;
  logic [2:0]     bit_idx_q;
  logic           stop_idx_q;
  logic [7:0]     shift_q;
  logic [15:0]    remaining_q;
  logic           tx_q;
  logic           busy_q;
  logic           packet_ready_q;
  logic           data_ready_q;

  logic bit_wrap;
  logic byte_done;
  logic pkt_accept;
  logic data_take;

  // Timing events decoded from the current registered state.
  assign bit_wrap   = (ser_q != SER_IDLE) && (bit_cnt_q == BIT_LAST);
  assign byte_done  = (ser_q == SER_STOP) && bit_wrap && (stop_idx_q == STOP_LAST);
  assign pkt_accept = packet_valid && packet_ready_q;
  assign data_take  = data_valid && data_ready_q;

  // Packet sequencer, byte serializer and bit timer with registered outputs.
  always_ff @(posedge clock) begin
    // NOTE: clear is synchronous and is tested first, so it beats any
    // handshake in the same cycle; a half-sent frame is simply dropped.
    if (clear) begin
      pkt_q          <= PKT_IDLE;
      ser_q          <= SER_IDLE;
      bit_cnt_q      <= '0;
      bit_idx_q      <= '0;
      stop_idx_q     <= 1'b0;
      shift_q        <= '0;
      remaining_q    <= '0;
      tx_q           <= 1'b1;
      busy_q         <= 1'b0;
      packet_ready_q <= 1'b1;
      data_ready_q   <= 1'b0;
    end else begin
      // Bit timer: free-runs 0..CLOCKS_PER_BIT-1 while a frame is in flight.
      if (ser_q == SER_IDLE || bit_wrap) begin
        bit_cnt_q <= '0;
      end else begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end

      // Serializer: each state lasts one bit time and hands over on wrap.
      case (ser_q)
        SER_START: begin
          if (bit_wrap) begin
            ser_q     <= SER_DATA;
            bit_idx_q <= 3'd0;
            tx_q      <= shift_q[0];
          end
        end
        SER_DATA: begin
          if (bit_wrap) begin
            if (bit_idx_q == 3'd7) begin
              if (INCLUDE_PARITY != 0) begin
                ser_q <= SER_PARITY;
                tx_q  <= ^shift_q;
              end else begin
                ser_q      <= SER_STOP;
                stop_idx_q <= 1'b0;
                tx_q       <= 1'b1;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[bit_idx_q + 3'd1];
            end
          end
        end
        SER_PARITY: begin
          if (bit_wrap) begin
            ser_q      <= SER_STOP;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
          end
        end
        SER_STOP: begin
          if (bit_wrap) begin
            if (stop_idx_q == STOP_LAST) begin
              ser_q <= SER_IDLE;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end
        end
        default: begin
          tx_q <= 1'b1;
        end
      endcase

      // Packet sequencer. NOTE: these non-blocking writes come after the
      // serializer's, so loading a new byte here overrides its return to
      // idle in the same edge and the next start bit follows with no gap.
      case (pkt_q)
        PKT_IDLE: begin
          if (pkt_accept) begin
            remaining_q    <= packet_length;
            shift_q        <= HEADER_BYTE;
            ser_q          <= SER_START;
            bit_cnt_q      <= '0;
            tx_q           <= 1'b0;
            busy_q         <= 1'b1;
            packet_ready_q <= 1'b0;
            pkt_q          <= PKT_HEADER;
          end
        end
        PKT_HEADER: begin
          if (byte_done) begin
            shift_q   <= remaining_q[15:8];
            ser_q     <= SER_START;
            bit_cnt_q <= '0;
            tx_q      <= 1'b0;
            pkt_q     <= PKT_LEN_HI;
          end
        end
        PKT_LEN_HI: begin
          if (byte_done) begin
            shift_q   <= remaining_q[7:0];
            ser_q     <= SER_START;
            bit_cnt_q <= '0;
            tx_q      <= 1'b0;
            pkt_q     <= PKT_LEN_LO;
          end
        end
        PKT_LEN_LO: begin
          if (byte_done) begin
            if (remaining_q == 16'd0) begin
              pkt_q          <= PKT_IDLE;
              busy_q         <= 1'b0;
              packet_ready_q <= 1'b1;
            end else begin
              pkt_q        <= PKT_PAYLOAD;
              data_ready_q <= 1'b1;
            end
          end
        end
        PKT_PAYLOAD: begin
          if (data_take) begin
            shift_q      <= data;
            ser_q        <= SER_START;
            bit_cnt_q    <= '0;
            tx_q         <= 1'b0;
            data_ready_q <= 1'b0;
            if (remaining_q != 16'd0) begin
              remaining_q <= remaining_q - 16'd1;
            end
          end else if (byte_done) begin
            if (remaining_q == 16'd0) begin
              pkt_q          <= PKT_IDLE;
              busy_q         <= 1'b0;
              packet_ready_q <= 1'b1;
            end else begin
              data_ready_q <= 1'b1;
            end
          end
        end
        default: begin
          pkt_q <= PKT_IDLE;
        end
      endcase
    end
  end

  assign packet_ready = packet_ready_q;
  assign data_ready   = data_ready_q;
  assign uart_tx      = tx_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_packet_tx.sv
// Bench for uart_packet_tx: two instances at 4 clocks per bit, one with even
// parity and one stop bit, one with no parity and two stop bits. Expected
// line waveforms are built from the framing rules, and a UART receiver plus
// packet parser decode the captured line.
module tb_uart_packet_tx;

  localparam int CPB = 4;

  logic        clock;
  logic        clear;
  logic        packet_valid;
  logic [15:0] packet_length;
  logic        data_valid;
  logic [7:0]  data;
  logic        sel;

  logic pr_a, dr_a, tx_a, busy_a;
  logic pr_b, dr_b, tx_b, busy_b;
  logic pv_a, pv_b;
  logic obs_tx, obs_busy, obs_pr, obs_dr;

  assign pv_a     = packet_valid & ~sel;
  assign pv_b     = packet_valid & sel;
  assign obs_tx   = sel ? tx_b   : tx_a;
  assign obs_busy = sel ? busy_b : busy_a;
  assign obs_pr   = sel ? pr_b   : pr_a;
  assign obs_dr   = sel ? dr_b   : dr_a;

  uart_packet_tx #(.CLOCKS_PER_BIT(CPB), .INCLUDE_PARITY(1), .STOP_BITS(1)) dut_a (
    .clock(clock), .clear(clear),
    .packet_valid(pv_a), .packet_length(packet_length), .packet_ready(pr_a),
    .data_valid(data_valid), .data(data), .data_ready(dr_a),
    .uart_tx(tx_a), .busy(busy_a)
  );

  uart_packet_tx #(.CLOCKS_PER_BIT(CPB), .INCLUDE_PARITY(0), .STOP_BITS(2)) dut_b (
    .clock(clock), .clear(clear),
    .packet_valid(pv_b), .packet_length(packet_length), .packet_ready(pr_b),
    .data_valid(data_valid), .data(data), .data_ready(dr_b),
    .uart_tx(tx_b), .busy(busy_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] pay[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] rx_bytes[$];
  bit         exp_tx[$];
  bit         exp_dr[$];
  bit         tx_tr[$];
  bit         dr_tr[$];
  int         rx_errs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference line waveform: framing bytes back to back, each payload byte
  // preceded by one idle cycle (plus any stall) during which data_ready is 1.
  function automatic void build_expected(input int len, input int par, input int sb,
                                         input int stall_idx, input int stall_cyc);
    logic [15:0] l16;
    logic [7:0]  b;
    bit          bits[$];
    int          gap;
    l16 = 16'(len);
    exp_bytes.delete();
    exp_tx.delete();
    exp_dr.delete();
    exp_bytes.push_back(8'h51);
    exp_bytes.push_back(l16[15:8]);
    exp_bytes.push_back(l16[7:0]);
    foreach (pay[i]) exp_bytes.push_back(pay[i]);
    foreach (exp_bytes[j]) begin
      b = exp_bytes[j];
      if (j >= 3) begin
        gap = 1 + (((j - 3) == stall_idx) ? stall_cyc : 0);
        for (int g = 0; g < gap; g++) begin
          exp_tx.push_back(1'b1);
          exp_dr.push_back(1'b1);
        end
      end
      bits.delete();
      bits.push_back(1'b0);
      for (int k = 0; k < 8; k++) bits.push_back(b[k]);
      if (par != 0) bits.push_back(^b);
      for (int s = 0; s < sb; s++) bits.push_back(1'b1);
      foreach (bits[k]) begin
        for (int c = 0; c < CPB; c++) begin
          exp_tx.push_back(bits[k]);
          exp_dr.push_back(1'b0);
        end
      end
    end
  endfunction

  function automatic bit tr_at(input int idx);
    return (idx < tx_tr.size()) ? tx_tr[idx] : 1'b1;
  endfunction

  // Mid-bit sampling UART receiver over the captured line.
  function automatic void decode(input int par, input int sb);
    int         i;
    int         mid;
    logic [7:0] v;
    rx_bytes.delete();
    rx_errs = 0;
    i = 0;
    while (i < tx_tr.size()) begin
      if (tx_tr[i] == 1'b0) begin
        mid = i + CPB / 2;
        if (tr_at(mid) != 1'b0) rx_errs++;
        for (int k = 0; k < 8; k++) v[k] = tr_at(mid + (k + 1) * CPB);
        if (par != 0 && tr_at(mid + 9 * CPB) != ^v) rx_errs++;
        for (int s = 0; s < sb; s++)
          if (tr_at(mid + (9 + par + s) * CPB) != 1'b1) rx_errs++;
        rx_bytes.push_back(v);
        i = mid + (8 + par + sb) * CPB;
      end else begin
        i++;
      end
    end
  endfunction

  // Serial-to-packet receiver: valid when header and length frame the bytes.
  function automatic bit rx_packet_valid();
    if (rx_bytes.size() < 3) return 1'b0;
    if (rx_bytes[0] != 8'h51) return 1'b0;
    return (int'({rx_bytes[1], rx_bytes[2]}) + 3) == rx_bytes.size();
  endfunction

  // Offer one packet on the selected instance and capture it while busy.
  task automatic run_packet(input string tag, input int len, input int par, input int sb,
                            input int stall_idx, input int stall_cyc);
    int idx, stall_left, cyc, bad_tx, bad_dr, bad_b, pr_bad, dr_rises;
    bit hs, stall_done, prev_dr;
    build_expected(len, par, sb, stall_idx, stall_cyc);
    tx_tr.delete();
    dr_tr.delete();
    @(negedge clock);
    packet_valid  = 1'b1;
    packet_length = 16'(len);
    data_valid    = 1'b1;
    data          = (pay.size() > 0) ? pay[0] : 8'($urandom);
    @(negedge clock);
    packet_length = 16'($urandom);
    idx = 0; hs = 1'b0; stall_left = 0; stall_done = 1'b0; cyc = 0; pr_bad = 0;
    while (obs_busy && cyc < 20000) begin
      if (hs) begin
        idx++;
        data = (idx < pay.size()) ? pay[idx] : 8'($urandom);
        hs = 1'b0;
      end
      tx_tr.push_back(obs_tx);
      dr_tr.push_back(obs_dr);
      if (obs_pr) pr_bad++;
      packet_valid = 1'b1;
      if (obs_dr && idx == stall_idx && !stall_done) begin
        stall_left = stall_cyc;
        stall_done = 1'b1;
      end
      if (stall_left > 0) begin
        data_valid = 1'b0;
        stall_left--;
      end else begin
        data_valid = 1'b1;
      end
      if (obs_dr && data_valid) hs = 1'b1;
      cyc++;
      @(negedge clock);
    end
    packet_valid = 1'b0;
    data_valid   = 1'b0;
    check({tag, " finished in time"}, 32'(cyc < 20000), 32'd1);
    check({tag, " busy low after"}, 32'(obs_busy), 32'd0);
    check({tag, " packet_ready after"}, 32'(obs_pr), 32'd1);
    check({tag, " packet_ready low while busy"}, 32'(pr_bad), 32'd0);
    check({tag, " busy cycles"}, 32'(tx_tr.size()), 32'(exp_tx.size()));
    bad_tx = 0; bad_dr = 0; dr_rises = 0; prev_dr = 1'b0;
    for (int i = 0; i < tx_tr.size() && i < exp_tx.size(); i++) begin
      if (tx_tr[i] != exp_tx[i]) bad_tx++;
      if (dr_tr[i] != exp_dr[i]) bad_dr++;
    end
    foreach (dr_tr[i]) begin
      if (dr_tr[i] && !prev_dr) dr_rises++;
      prev_dr = dr_tr[i];
    end
    check({tag, " uart_tx cycles differing"}, 32'(bad_tx), 32'd0);
    check({tag, " data_ready cycles differing"}, 32'(bad_dr), 32'd0);
    check({tag, " data_ready pulses"}, 32'(dr_rises), 32'(len));
    decode(par, sb);
    check({tag, " rx parity/stop errors"}, 32'(rx_errs), 32'd0);
    check({tag, " rx byte count"}, 32'(rx_bytes.size()), 32'(exp_bytes.size()));
    bad_b = 0;
    for (int i = 0; i < rx_bytes.size() && i < exp_bytes.size(); i++)
      if (rx_bytes[i] != exp_bytes[i]) bad_b++;
    check({tag, " rx bytes differing"}, 32'(bad_b), 32'd0);
    check({tag, " serial_to_packet_valid"}, 32'(rx_packet_valid()), 32'd1);
  endtask

  initial begin
    logic [10:0] frame;
    logic [7:0]  ref6[6];
    int          cnt;
    int          len;
    int          st;

    clear = 1'b1; packet_valid = 1'b0; packet_length = '0;
    data_valid = 1'b0; data = '0; sel = 1'b0;

    // Reset values after three cycles of clear.
    repeat (3) @(negedge clock);
    clear = 1'b0;
    check("reset uart_tx", 32'(tx_a), 32'd1);
    check("reset busy", 32'(busy_a), 32'd0);
    check("reset packet_ready", 32'(pr_a), 32'd1);
    check("reset data_ready", 32'(dr_a), 32'd0);
    check("reset uart_tx b", 32'(tx_b), 32'd1);

    // Zero-length packet: three frames of 44 cycles, no data_ready.
    pay.delete();
    run_packet("zero_len", 0, 1, 1, -1, 0);
    check("zero_len busy span", 32'(tx_tr.size()), 32'd132);
    cnt = 0;
    foreach (dr_tr[i]) if (dr_tr[i]) cnt++;
    check("zero_len data_ready count", 32'(cnt), 32'd0);
    for (int k = 0; k < 11; k++) frame[k] = tr_at(k * CPB + 2);
    check("zero_len header frame", 32'(frame), 32'h6A2);

    // Length-3 packet with continuous data_valid.
    pay.delete();
    pay.push_back(8'hA5); pay.push_back(8'hFF); pay.push_back(8'h00);
    run_packet("len3", 3, 1, 1, -1, 0);
    ref6 = '{8'h51, 8'h00, 8'h03, 8'hA5, 8'hFF, 8'h00};
    for (int i = 0; i < 6; i++)
      check($sformatf("len3 byte %0d", i), 32'((i < rx_bytes.size()) ? rx_bytes[i] : 8'hxx),
            32'(ref6[i]));
    for (int k = 0; k < 3; k++)
      check($sformatf("len3 parity %0d", k), 32'(tr_at(132 + k * 45 + 1 + 9 * CPB + 2)), 32'd0);

    // Payload stall of 50 cycles before the second byte.
    pay.delete();
    pay.push_back(8'($urandom)); pay.push_back(8'($urandom));
    run_packet("stall", 2, 1, 1, 1, 50);

    // No parity, two stop bits, payload 0x80.
    sel = 1'b1;
    pay.delete();
    pay.push_back(8'h80);
    run_packet("p0s2", 1, 0, 2, -1, 0);
    for (int k = 0; k < 11; k++) frame[k] = tr_at(133 + k * CPB + 2);
    check("p0s2 payload frame", 32'(frame), 32'h700);
    sel = 1'b0;

    // Random packets with random stalls.
    for (int r = 0; r < 4; r++) begin
      len = int'($urandom_range(1, 4));
      pay.delete();
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
      st = int'($urandom_range(0, 6));
      run_packet($sformatf("rand%0d", r), len, 1, 1, int'($urandom_range(0, len - 1)), st);
    end

    // Clear mid-packet, held three cycles; the frame is abandoned.
    @(negedge clock);
    packet_valid = 1'b1; packet_length = 16'd3;
    @(negedge clock);
    packet_valid = 1'b0;
    repeat (70) @(negedge clock);
    clear = 1'b1;
    repeat (3) @(negedge clock);
    clear = 1'b0;
    check("midclear uart_tx", 32'(tx_a), 32'd1);
    check("midclear busy", 32'(busy_a), 32'd0);
    check("midclear packet_ready", 32'(pr_a), 32'd1);
    check("midclear data_ready", 32'(dr_a), 32'd0);
    cnt = 0;
    repeat (100) begin
      @(negedge clock);
      if (tx_a && !busy_a) cnt++;
    end
    check("midclear line stays idle", 32'(cnt), 32'd100);

    // Clear together with a descriptor handshake: nothing is accepted.
    @(negedge clock);
    packet_valid = 1'b1; packet_length = 16'd1; clear = 1'b1;
    @(negedge clock);
    packet_valid = 1'b0; clear = 1'b0;
    check("clear vs accept busy", 32'(busy_a), 32'd0);
    check("clear vs accept packet_ready", 32'(pr_a), 32'd1);
    @(negedge clock);
    check("clear vs accept still idle", 32'({busy_a, tx_a}), 32'b01);

    // Clear during data bit 3 of the low length byte.
    @(negedge clock);
    packet_valid = 1'b1; packet_length = 16'd1;
    @(negedge clock);
    packet_valid = 1'b0;
    repeat (105) @(negedge clock);
    check("len_lo bit3 in flight", 32'({busy_a, tx_a}), 32'b10);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("lenlo clear uart_tx", 32'(tx_a), 32'd1);
    check("lenlo clear busy", 32'(busy_a), 32'd0);
    check("lenlo clear ready", 32'({pr_a, dr_a}), 32'b10);
    pay.delete();
    pay.push_back(8'($urandom));
    run_packet("after_clear", 1, 1, 1, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
